// File: rtl/display_scheduler.sv
// display_scheduler: shares the digit display path between four measurement sources
// (hex, ADC average, distance, voltage). Debounces the mode button, optionally
// auto-cycles modes on a dwell timer and latches the selected source's BCD word.
//
// Build option: define DISPLAY_SCHED_AUTO_EN to build the dwell timer and auto-cycle.
// Without it, auto_en is ignored and only button presses advance the mode.
//
// state  | meaning
// S_WAIT | mode just entered (or reset); data=0, data_valid=0, waiting for first strobe
// S_SHOW | a word from the current source is latched; refreshed on strobes unless hold
module display_scheduler #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DWELL_CYCLES    = 100_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_n,
   input  logic        auto_en,
   input  logic        hold,
   input  logic [63:0] src_data,
   input  logic [3:0]  src_valid,
   output logic [1:0]  select,
   output logic [15:0] data,
   output logic        data_valid,
   output logic        mode_change
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {S_WAIT, S_SHOW} state_t;

   logic [1:0]      sync_q;
   logic            btn_acc_q, btn_acc_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            press_q, press_d;
   logic            dwell_evt;
   logic            advance;

   state_t          state_q;
   logic [1:0]      select_q;
   logic [15:0]     data_q;
   logic            data_valid_q;
   logic            mode_change_q;

   logic [15:0]     src_word;
   logic            src_strobe;

   // Two-flop synchronizer; idle level of the button is high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], btn_n};
   end

   // Debounce: count consecutive disagreeing cycles; flip accepted level on the last one.
   // A 1->0 flip is a press; it is registered, so the mode advances one edge later.
   always_comb begin
      db_cnt_d  = db_cnt_q;
      btn_acc_d = btn_acc_q;
      press_d   = 1'b0;
      if (sync_q[1] == btn_acc_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_d  = '0;
         btn_acc_d = ~btn_acc_q;
         press_d   = btn_acc_q;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_acc_q <= 1'b1;
         db_cnt_q  <= '0;
         press_q   <= 1'b0;
      end else begin
         btn_acc_q <= btn_acc_d;
         db_cnt_q  <= db_cnt_d;
         press_q   <= press_d;
      end
   end

`ifdef DISPLAY_SCHED_AUTO_EN
   localparam int DW_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

   logic [DW_W-1:0] dwell_cnt_q, dwell_cnt_d;

   assign dwell_evt = auto_en && (dwell_cnt_q == DW_LAST);

   // Dwell counter: idle at 0 when auto-cycle is off; any advance restarts the dwell
   always_comb begin
      dwell_cnt_d = dwell_cnt_q + 1'b1;
      if (!auto_en || advance) dwell_cnt_d = '0;
   end

   // Dwell counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dwell_cnt_q <= '0;
      else          dwell_cnt_q <= dwell_cnt_d;
   end
`else
   logic unused_auto_en;
   assign unused_auto_en = auto_en ^ (DWELL_CYCLES == 0);
   assign dwell_evt      = 1'b0;
`endif

   // A press and a dwell expiry on the same edge collapse into one advance
   assign advance    = press_q | dwell_evt;
   assign src_word   = src_data[{select_q, 4'b0000} +: 16];
   assign src_strobe = src_valid[select_q];

   // Mode select and data FSM; an advance always wins over a same-edge strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_WAIT;
         select_q      <= 2'b00;
         data_q        <= 16'h0000;
         data_valid_q  <= 1'b0;
         mode_change_q <= 1'b0;
      end else begin
         mode_change_q <= advance;
         if (advance) begin
            select_q     <= select_q + 2'd1;
            state_q      <= S_WAIT;
            data_q       <= 16'h0000;
            data_valid_q <= 1'b0;
         end else begin
            case (state_q)
               S_WAIT: begin
                  if (src_strobe) begin
                     data_q       <= src_word;
                     data_valid_q <= 1'b1;
                     state_q      <= S_SHOW;
                  end
               end
               S_SHOW: begin
                  if (src_strobe && !hold) data_q <= src_word;
               end
               default: begin
                  state_q      <= S_WAIT;
                  data_q       <= 16'h0000;
                  data_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign select      = select_q;
   assign data        = data_q;
   assign data_valid  = data_valid_q;
   assign mode_change = mode_change_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from an edge-level reference model.
module tb_display_scheduler;

   localparam int DEB   = 4;
   localparam int DWELL = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        btn_n = 1'b1;
   logic        auto_en = 1'b0;
   logic        hold = 1'b0;
   logic [63:0] src_data = 64'h0;
   logic [3:0]  src_valid = 4'h0;
   logic [1:0]  select;
   logic [15:0] data;
   logic        data_valid;
   logic        mode_change;

   display_scheduler #(.DEBOUNCE_CYCLES(DEB), .DWELL_CYCLES(DWELL)) dut (
      .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .auto_en(auto_en), .hold(hold),
      .src_data(src_data), .src_valid(src_valid), .select(select), .data(data),
      .data_valid(data_valid), .mode_change(mode_change)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
      end
   endtask

   task automatic fail_now(string msg);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (edge %0d)", msg, edge_cnt);
   endtask

   typedef struct {int e; logic [1:0] sel;} mode_exp_t;
   typedef struct {int e; logic v; logic [15:0] d;} data_exp_t;

   mode_exp_t mode_q[$];
   data_exp_t data_q[$];
   bit        press_at[int];

   // Reference model state (what the display should show after each edge)
   logic [1:0]  m_sel;
   bit          m_show;
   logic [15:0] m_data;
   logic [16:0] m_prev;
`ifdef DISPLAY_SCHED_AUTO_EN
   int          m_since;
`endif

   // Driven stimulus values
   logic        b_btn = 1'b1;
   logic        b_auto = 1'b0;
   logic        b_hold = 1'b0;
   logic [3:0]  b_sv = 4'h0;
   logic [63:0] b_sd = 64'h0;
   bit          rnd = 1'b0;
   bit          mon_en = 1'b0;
   logic [16:0] mon_prev = 17'h0;

   function automatic void model_reset();
      m_sel  = 2'd0;
      m_show = 1'b0;
      m_data = 16'h0;
      m_prev = 17'h0;
`ifdef DISPLAY_SCHED_AUTO_EN
      m_since = 0;
`endif
      press_at.delete();
      mode_q.delete();
      data_q.delete();
   endfunction

   // Outcome of edge e given the inputs presented to it
   function automatic void model_edge(int e);
      bit adv;
      adv = press_at.exists(e);
`ifdef DISPLAY_SCHED_AUTO_EN
      if (b_auto) begin
         m_since++;
         if (m_since == DWELL) adv = 1'b1;
      end else begin
         m_since = 0;
      end
      if (adv) m_since = 0;
`endif
      if (adv) begin
         m_sel  = m_sel + 2'd1;
         m_show = 1'b0;
         m_data = 16'h0;
         mode_q.push_back('{e, m_sel});
      end else if (b_sv[m_sel] && !(m_show && b_hold)) begin
         m_data = b_sd[int'(m_sel)*16 +: 16];
         m_show = 1'b1;
      end
      if ({m_show, m_data} != m_prev) begin
         data_q.push_back('{e, m_show, m_data});
         m_prev = {m_show, m_data};
      end
   endfunction

   // Monitor: pop an expectation whenever the DUT presents a mode change or new data
   always @(negedge clk) begin
      mode_exp_t me;
      data_exp_t de;
      if (mon_en) begin
         if (mode_change) begin
            if (mode_q.size() == 0) fail_now("unexpected mode_change");
            else begin
               me = mode_q.pop_front();
               check("mode_change edge", edge_cnt, me.e);
               check("select after advance", {30'b0, select}, {30'b0, me.sel});
            end
         end
         if ({data_valid, data} != mon_prev) begin
            mon_prev = {data_valid, data};
            if (data_q.size() == 0) fail_now("unexpected data/data_valid change");
            else begin
               de = data_q.pop_front();
               check("data update edge", edge_cnt, de.e);
               check("data_valid,data", {15'b0, data_valid, data}, {15'b0, de.v, de.d});
            end
         end
         while (mode_q.size() > 0 && mode_q[0].e < edge_cnt) begin
            fail_now($sformatf("missing mode_change expected at edge %0d", mode_q[0].e));
            void'(mode_q.pop_front());
         end
         while (data_q.size() > 0 && data_q[0].e < edge_cnt) begin
            fail_now($sformatf("missing data update expected at edge %0d", data_q[0].e));
            void'(data_q.pop_front());
         end
      end
   end

   // One clock of stimulus, applied after a falling edge
   task automatic step();
      if (rnd) begin
         b_hold = ($urandom_range(0, 3) == 0);
         b_sv   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         b_sd   = {$urandom, $urandom};
         b_auto = ($urandom_range(0, 7) != 0);
      end
      btn_n     = b_btn;
      auto_en   = b_auto;
      hold      = b_hold;
      src_valid = b_sv;
      src_data  = b_sd;
      model_edge(edge_cnt + 1);
      @(negedge clk);
      b_sv = 4'h0;
   endtask

   // Button low for low_len samples then high for gap samples
   task automatic press(int low_len, int gap);
      if (low_len >= DEB) press_at[edge_cnt + 3 + DEB] = 1'b1;
      b_btn = 1'b0;
      repeat (low_len) step();
      b_btn = 1'b1;
      repeat (gap) step();
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, " select"}, {30'b0, select}, 32'd0);
      check({tag, " data"}, {16'b0, data}, 32'd0);
      check({tag, " data_valid"}, {31'b0, data_valid}, 32'd0);
      check({tag, " mode_change"}, {31'b0, mode_change}, 32'd0);
   endtask

   task automatic restart();
      @(negedge clk);
      model_reset();
      mon_prev = 17'h0;
      reset_n  = 1'b1;
      mon_en   = 1'b1;
   endtask

   initial begin
`ifdef DISPLAY_SCHED_AUTO_EN
      int w;
`endif
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("power-on reset");
      restart();
      repeat (3) step();

      // Bounce shorter than the debounce window, then clean presses
      press(3, 10);
      check("bounce ignored select", {30'b0, select}, 32'd0);
      press(8, 10);
      check("first press select", {30'b0, select}, 32'd1);
      repeat (3) press(8, 10);
      check("four presses wrap select", {30'b0, select}, 32'd0);

      // Data load and hold on mode 1
      press(8, 10);
      b_sd = 64'h0;
      b_sd[31:16] = 16'h005A; b_sv = 4'b0010; step();
      check("load mode1 data", {16'b0, data}, 32'h005A);
      check("load mode1 valid", {31'b0, data_valid}, 32'd1);
      b_sd[47:32] = 16'h1234; b_sv = 4'b0100; step();
      check("non-selected strobe ignored", {16'b0, data}, 32'h005A);
      b_hold = 1'b1; step();
      b_sd[31:16] = 16'h5A5A; b_sv = 4'b0010; step();
      check("hold freezes data", {16'b0, data}, 32'h005A);
      b_hold = 1'b0; step();
      b_sv = 4'b0010; step();
      check("reload after hold", {16'b0, data}, 32'h5A5A);

      // Mode switch clears the latched word
      press(8, 10);
      b_sd[47:32] = 16'h0165; b_sv = 4'b0100; step();
      check("load mode2 data", {16'b0, data}, 32'h0165);
      press(8, 10);
      check("switch select", {30'b0, select}, 32'd3);
      check("switch clears data", {16'b0, data}, 32'd0);
      check("switch clears valid", {31'b0, data_valid}, 32'd0);
      b_sd[63:48] = 16'h5151; b_sv = 4'b1000; step();
      check("load mode3 data", {16'b0, data}, 32'h5151);

      // Strobes every cycle through an advance: the advance edge drops its strobe
      b_sd = 64'h1111_2222_3333_4444;
      press_at[edge_cnt + 3 + DEB] = 1'b1;
      b_btn = 1'b0;
      repeat (8) begin b_sv = 4'hF; step(); end
      b_btn = 1'b1;
      repeat (6) step();
      check("post-wrap load data", {16'b0, data}, 32'h4444);

      // Asynchronous reset from mode 2 / SHOW
      press(8, 10);
      press(8, 10);
      b_sd[47:32] = 16'h0777; b_sv = 4'b0100; step();
      check("pre-reset select", {30'b0, select}, 32'd2);
      check("pre-reset valid", {31'b0, data_valid}, 32'd1);
      mon_en = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("async reset");
      restart();
      repeat (3) step();

`ifdef DISPLAY_SCHED_AUTO_EN
      // Auto-cycle from reset release, including the 3->0 wrap
      mon_en = 1'b0;
      reset_n = 1'b0;
      b_auto = 1'b1;
      restart();
      repeat (70) step();
      check("auto-cycle select after 70 edges", {30'b0, select}, {30'b0, m_sel});
      // Land a press event on the same edge as a dwell expiry
      w = (DWELL - m_since) - (3 + DEB);
      while (w < 0) w += DWELL;
      repeat (w) step();
      press(8, 10);
      repeat (30) step();
      check("select after coincident events", {30'b0, select}, {30'b0, m_sel});
      b_auto = 1'b0;
      step();
`else
      b_auto = 1'b1;
      repeat (100) step();
      check("auto_en ignored select", {30'b0, select}, {30'b0, m_sel});
      b_auto = 1'b0;
      step();
`endif

      // Randomized traffic
      rnd = 1'b1;
      repeat (25) press($urandom_range(1, 8), $urandom_range(DEB + 2, DEB + 10));
      rnd = 1'b0;
      b_hold = 1'b0;
      b_auto = 1'b0;
      repeat (5) step();
      check("final select", {30'b0, select}, {30'b0, m_sel});
      check("final data", {15'b0, data_valid, data}, {15'b0, m_show, m_data});
      check("mode expectations drained", mode_q.size(), 32'd0);
      check("data expectations drained", data_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
